// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared writeback constants and types
// Purpose: register/data widths, the hard-wired zero register, the writeback
// source selector and the buffered-result entry used by the writeback stage.
package cpu_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of writeback entries
// Purpose: buffers LSU results until the writeback port is granted to them.
// Ports:
//   iClk, iRst       clock, asynchronous active-high reset
//   iPush, iPushData write an entry (ignored while full)
//   iPop             drop the head entry (ignored while empty)
//   oHead            entry at the read pointer
//   oCount           number of stored entries
//   oEmpty, oFull    count == 0, count == DEPTH
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iPush,
    input  wb_entry_t                  iPushData,
    input  logic                       iPop,
    output wb_entry_t                  oHead,
    output logic [$clog2(DEPTH+1)-1:0] oCount,
    output logic                       oEmpty,
    output logic                       oFull
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign oEmpty  = (count_q == '0);
    assign oFull   = (count_q == CW'(DEPTH));
    assign oCount  = count_q;
    assign oHead   = mem_q[rptr_q];
    assign push_ok = iPush && !oFull;
    assign pop_ok  = iPop && !oEmpty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count/pointers.
    always_ff @(posedge iClk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= iPushData;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter in front of the register-file write port
// Purpose: merges ALU results (priority) and buffered LSU results onto one
// write port, bounds LSU starvation, and tracks pending destination registers.
// Ports:
//   iClk, iRst                            clock, asynchronous active-high reset
//   iAluValid/oAluReady/iAluAddr/iAluData ALU result handshake
//   iLsuValid/oLsuReady/iLsuAddr/iLsuData LSU result handshake into the FIFO
//   iIssueValid/iIssueAddr                marks a destination as pending
//   iAddrA/oBusyA, iAddrB/oBusyB          read-after-write hazard queries
//   oWrite/oAddrC/oRegC                   registered register-file write port
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = cpu_pkg::AW,
    parameter int DW           = cpu_pkg::DW
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iAluValid,
    output logic          oAluReady,
    input  logic [AW-1:0] iAluAddr,
    input  logic [DW-1:0] iAluData,
    input  logic          iLsuValid,
    output logic          oLsuReady,
    input  logic [AW-1:0] iLsuAddr,
    input  logic [DW-1:0] iLsuData,
    input  logic          iIssueValid,
    input  logic [AW-1:0] iIssueAddr,
    input  logic [AW-1:0] iAddrA,
    input  logic [AW-1:0] iAddrB,
    output logic          oBusyA,
    output logic          oBusyB,
    output logic          oWrite,
    output logic [AW-1:0] oAddrC,
    output logic [DW-1:0] oRegC
);

    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int CW   = $clog2(DEPTH + 1);

    wb_entry_t       lsu_entry;
    wb_entry_t       fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_pop;
    wb_src_t         src;

    logic [SW-1:0]   starve_q, starve_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NREG-1:0] pending_q, pending_d;

    assign lsu_entry = '{addr: iLsuAddr, data: iLsuData};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (iLsuValid),
        .iPushData (lsu_entry),
        .iPop      (fifo_pop),
        .oHead     (fifo_head),
        .oCount    (fifo_count),
        .oEmpty    (fifo_empty),
        .oFull     (fifo_full)
    );

    // Both readies come from registered state only, so neither handshake can
    // form a combinational loop with the upstream stages.
    assign oAluReady = (starve_q < SW'(STARVE_LIMIT));
    assign oLsuReady = !fifo_full;

    always_comb begin
        src = WB_NONE;
        if (iAluValid && oAluReady) begin
            src = WB_ALU;
        end else if (fifo_count != '0) begin
            src = WB_LSU;
        end
        fifo_pop = (src == WB_LSU);
    end

    // Counts ALU wins that overtook a waiting LSU result; once it saturates,
    // oAluReady drops and the FIFO head gets the port.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if ((src == WB_ALU) && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Address/data hold when idle; only the write strobe falls back to 0.
    always_comb begin
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (src)
            WB_ALU: begin
                addr_d  = iAluAddr;
                data_d  = iAluData;
                write_d = (iAluAddr != ZERO_REG);
            end
            WB_LSU: begin
                addr_d  = fifo_head.addr;
                data_d  = fifo_head.data;
                write_d = (fifo_head.addr != ZERO_REG);
            end
            default: begin
                write_d = 1'b0;
            end
        endcase
    end

    // Clear is applied before set so a re-issue on the retiring edge wins.
    always_comb begin
        pending_d = pending_q;
        if (write_q) begin
            pending_d[addr_q] = 1'b0;
        end
        if (iIssueValid && (iIssueAddr != ZERO_REG)) begin
            pending_d[iIssueAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            starve_q  <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign oWrite = write_q;
    assign oAddrC = addr_q;
    assign oRegC  = data_q;
    assign oBusyA = pending_q[iAddrA];
    assign oBusyB = pending_q[iAddrB];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard testbench for wb_arbiter
module tb_wb_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iAluValid, oAluReady;
    logic [4:0]  iAluAddr;
    logic [31:0] iAluData;
    logic        iLsuValid, oLsuReady;
    logic [4:0]  iLsuAddr;
    logic [31:0] iLsuData;
    logic        iIssueValid;
    logic [4:0]  iIssueAddr;
    logic [4:0]  iAddrA, iAddrB;
    logic        oBusyA, oBusyB;
    logic        oWrite;
    logic [4:0]  oAddrC;
    logic [31:0] oRegC;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_alu[$];
    exp_t exp_lsu[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    wb_arbiter dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iAluValid   (iAluValid),
        .oAluReady   (oAluReady),
        .iAluAddr    (iAluAddr),
        .iAluData    (iAluData),
        .iLsuValid   (iLsuValid),
        .oLsuReady   (oLsuReady),
        .iLsuAddr    (iLsuAddr),
        .iLsuData    (iLsuData),
        .iIssueValid (iIssueValid),
        .iIssueAddr  (iIssueAddr),
        .iAddrA      (iAddrA),
        .iAddrB      (iAddrB),
        .oBusyA      (oBusyA),
        .oBusyB      (oBusyB),
        .oWrite      (oWrite),
        .oAddrC      (oAddrC),
        .oRegC       (oRegC)
    );

    always #5 iClk = ~iClk;

    function automatic exp_t mk(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_alu.size() != 0 || exp_lsu.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain_left", exp_alu.size() + exp_lsu.size(), 0);
        tick();
        tick();
    endtask

    // Monitor: every register-file write must match the head of the LSU queue
    // or, failing that, the head of the ALU queue; per-source order is kept.
    always @(negedge iClk) begin
        if (!iRst && oWrite) begin
            total++;
            if (exp_lsu.size() != 0 && exp_lsu[0].addr == oAddrC && exp_lsu[0].data == oRegC) begin
                void'(exp_lsu.pop_front());
            end else if (exp_alu.size() != 0) begin
                mon_e = exp_alu.pop_front();
                if (mon_e.addr !== oAddrC || mon_e.data !== oRegC) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%0h want addr=%0d data=%0h",
                             oAddrC, oRegC, mon_e.addr, mon_e.data);
                end
            end else begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h want no write", oAddrC, oRegC);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stalls, na, nl, nr, first_block, writes;
        logic acc, acc_a, acc_l;

        iRst = 1'b1;
        iAluValid = 0; iAluAddr = 0; iAluData = 0;
        iLsuValid = 0; iLsuAddr = 0; iLsuData = 0;
        iIssueValid = 0; iIssueAddr = 0;
        iAddrA = 0; iAddrB = 0;
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b0;
        tick();

        // Reset state
        check("rst_write", oWrite, 0);
        check("rst_addr", oAddrC, 0);
        check("rst_data", oRegC, 0);
        check("rst_lsu_ready", oLsuReady, 1);
        check("rst_alu_ready", oAluReady, 1);

        // ALU path
        check("alu_ready", oAluReady, 1);
        iAluValid = 1; iAluAddr = 3; iAluData = 32'hDEADBEEF;
        exp_alu.push_back(mk(5'd3, 32'hDEADBEEF));
        tick();
        iAluValid = 0;
        check("alu_write", oWrite, 1);
        check("alu_addr", oAddrC, 3);
        check("alu_data", oRegC, 32'hDEADBEEF);
        tick();
        check("alu_write_off", oWrite, 0);
        iAluValid = 1; iAluAddr = 0; iAluData = 32'h12345678;
        tick();
        iAluValid = 0;
        check("zero_no_write", oWrite, 0);
        check("zero_data_taken", oRegC, 32'h12345678);
        tick();
        check("idle_hold_data", oRegC, 32'h12345678);
        check("idle_no_write", oWrite, 0);

        // Scoreboard
        iAddrA = 9; iAddrB = 3;
        iIssueValid = 1; iIssueAddr = 9;
        tick();
        iIssueValid = 0;
        check("busyA_set", oBusyA, 1);
        check("busyB_clear", oBusyB, 0);
        iAluValid = 1; iAluAddr = 9; iAluData = 32'h99;
        exp_alu.push_back(mk(5'd9, 32'h99));
        tick();
        iAluValid = 0;
        check("busy_before_clear", oBusyA, 1);
        iIssueValid = 1; iIssueAddr = 9;
        tick();
        iIssueValid = 0;
        check("reissue_set_wins", oBusyA, 1);
        iAluValid = 1; iAluAddr = 9; iAluData = 32'h98;
        exp_alu.push_back(mk(5'd9, 32'h98));
        tick();
        iAluValid = 0;
        tick();
        check("busy_cleared", oBusyA, 0);
        iIssueValid = 1; iIssueAddr = 0; iAddrB = 0;
        tick();
        iIssueValid = 0;
        check("zero_never_busy", oBusyB, 0);
        drain();

        // Starvation: one LSU result, then a stream of ALU results
        iLsuValid = 1; iLsuAddr = 7; iLsuData = 32'h11;
        check("starve_lsu_ready", oLsuReady, 1);
        exp_lsu.push_back(mk(5'd7, 32'h11));
        tick();
        iLsuValid = 0;
        n = 0; stalls = 0;
        for (int cyc = 0; cyc < 16 && n < 10; cyc++) begin
            iAluValid = 1; iAluAddr = 5'(10 + n); iAluData = 32'hA0000000 + n;
            acc = oAluReady;
            if (acc) begin
                exp_alu.push_back(mk(5'(10 + n), 32'hA0000000 + n));
            end else begin
                stalls++;
                check("stall_after_4", n, 4);
            end
            tick();
            if (acc) n++;
            if (!acc) check("lsu_write_on_stall", oAddrC, 7);
        end
        iAluValid = 0;
        check("starve_all_alu", n, 10);
        check("starve_stalls", stalls, 1);
        drain();

        // FIFO full: ALU always valid, three back-to-back LSU results
        na = 0; nl = 0; first_block = -1;
        for (int cyc = 0; cyc < 80 && (nl < 3 || exp_lsu.size() != 0); cyc++) begin
            iAluValid = 1; iAluAddr = 5'(10 + (na % 8)); iAluData = 32'hB0000000 + na;
            iLsuValid = (nl < 3); iLsuAddr = 5'(20 + nl); iLsuData = 32'h60000000 + nl;
            acc_a = oAluReady;
            acc_l = (nl < 3) && oLsuReady;
            if (nl < 3 && !oLsuReady && first_block < 0) first_block = nl;
            if (acc_a) exp_alu.push_back(mk(5'(10 + (na % 8)), 32'hB0000000 + na));
            if (acc_l) exp_lsu.push_back(mk(5'(20 + nl), 32'h60000000 + nl));
            tick();
            if (acc_a) na++;
            if (acc_l) nl++;
        end
        iAluValid = 0; iLsuValid = 0;
        check("full_block_at", first_block, 2);
        check("full_all_pushed", nl, 3);
        drain();

        // Streaming 8 LSU results, ALU idle: push and pop every cycle, pointers wrap
        nl = 0; nr = 0;
        for (int cyc = 0; cyc < 30 && nl < 8; cyc++) begin
            iLsuValid = 1; iLsuAddr = 5'(16 + nl); iLsuData = 32'h50000000 + nl;
            acc = oLsuReady;
            if (acc) exp_lsu.push_back(mk(5'(16 + nl), 32'h50000000 + nl));
            else nr++;
            tick();
            if (acc) nl++;
        end
        iLsuValid = 0;
        check("stream_count", nl, 8);
        check("stream_never_blocked", nr, 0);
        drain();

        // Reset mid-operation: FIFO holds 2 entries, register 5 pending, write in flight
        iAddrA = 5;
        iIssueValid = 1; iIssueAddr = 5;
        iAluValid = 1; iAluAddr = 0; iAluData = 32'hFFFFFFFF;
        iLsuValid = 1; iLsuAddr = 20; iLsuData = 32'h77;
        tick();
        iIssueValid = 0;
        iAluAddr = 12; iAluData = 32'hCCCC;
        iLsuData = 32'h78;
        exp_alu.push_back(mk(5'd12, 32'hCCCC));
        tick();
        iAluValid = 0; iLsuValid = 0;
        check("pre_rst_busy", oBusyA, 1);
        check("pre_rst_full", oLsuReady, 0);
        check("pre_rst_write", oWrite, 1);
        #2 iRst = 1'b1;
        #1;
        check("mid_rst_write", oWrite, 0);
        check("mid_rst_addr", oAddrC, 0);
        check("mid_rst_data", oRegC, 0);
        check("mid_rst_lsu_ready", oLsuReady, 1);
        check("mid_rst_busy", oBusyA, 0);
        exp_alu.delete();
        exp_lsu.delete();
        @(posedge iClk);
        @(posedge iClk);
        #1 iRst = 1'b0;
        writes = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (oWrite) writes++;
        end
        check("post_rst_no_write", writes, 0);
        check("post_rst_busy", oBusyA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
